// File: rtl/data_mem_responder_if.sv
// Bundle of the CPU data port, host preload port, result dump port and status
// signals shared between the data memory responder and its surroundings.
interface data_mem_responder_if #(
    parameter int AW = 8
);
    logic          MemWrite;
    logic [31:0]   ALUResult;
    logic [31:0]   WriteData;
    logic [31:0]   ReadData;
    logic          start;

    logic          host_load_valid;
    logic          host_load_ready;
    logic [AW-1:0] host_load_addr;
    logic [31:0]   host_load_data;
    logic          host_load_last;

    logic          dump_valid;
    logic          dump_ready;
    logic [31:0]   dump_data;
    logic          dump_last;

    logic [1:0]    phase;

    modport slave (
        input  MemWrite, ALUResult, WriteData,
        input  host_load_valid, host_load_addr, host_load_data, host_load_last,
        input  dump_ready,
        output ReadData, start, host_load_ready,
        output dump_valid, dump_data, dump_last, phase
    );

    modport master (
        output MemWrite, ALUResult, WriteData,
        output host_load_valid, host_load_addr, host_load_data, host_load_last,
        output dump_ready,
        input  ReadData, start, host_load_ready,
        input  dump_valid, dump_data, dump_last, phase
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data RAM for the pipelined core that also sequences a run:
// host preload, CPU run until a store to DONE_ADDR, then a streamed result dump.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] DONE_ADDR   = 32'h0000_0FFC,
    parameter int unsigned DUMP_BASE   = 0,
    parameter int unsigned DUMP_LEN    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] LOAD = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DUMP = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [AW-1:0] BASE_IDX = AW'(DUMP_BASE);
    localparam logic [AW-1:0] LAST_CNT = AW'(DUMP_LEN - 1);

    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [1:0]    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          start_q;

    logic          cpuInRange;
    logic          cpuIsDone;
    logic [AW-1:0] cpuIdx;
    logic [AW-1:0] dumpIdx;
    logic          memWe;
    logic [AW-1:0] memWaddr;
    logic [31:0]   memWdata;

    assign cpuIdx     = bus.ALUResult[AW+1:2];
    assign cpuInRange = (bus.ALUResult[31:AW+2] == '0);
    assign cpuIsDone  = bus.MemWrite && (bus.ALUResult == DONE_ADDR);
    assign dumpIdx    = BASE_IDX + cnt_q;

    // Single write port: the host owns it in LOAD, the CPU in RUN, nobody otherwise.
    always_comb begin
        memWe    = 1'b0;
        memWaddr = bus.host_load_addr;
        memWdata = bus.host_load_data;
        if (state_q == LOAD) begin
            memWe = bus.host_load_valid;
        end else if (state_q == RUN) begin
            memWe    = bus.MemWrite && cpuInRange && !cpuIsDone;
            memWaddr = cpuIdx;
            memWdata = bus.WriteData;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            LOAD: begin
                if (bus.host_load_valid && bus.host_load_last) state_d = RUN;
            end
            RUN: begin
                if (cpuIsDone) state_d = DUMP;
            end
            DUMP: begin
                if (bus.dump_ready) begin
                    cnt_d = cnt_q + AW'(1);
                    if (cnt_q == LAST_CNT) state_d = DONE;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= (state_d == RUN);
        end
    end

    // RAM contents survive reset; only writes issued during the reset cycle are dropped.
    always_ff @(posedge clk) begin
        if (!reset && memWe) mem_q[memWaddr] <= memWdata;
    end

    assign bus.ReadData        = cpuInRange ? mem_q[cpuIdx] : 32'h0;
    assign bus.start           = start_q;
    assign bus.host_load_ready = (state_q == LOAD);
    assign bus.dump_valid      = (state_q == DUMP);
    assign bus.dump_data       = mem_q[dumpIdx];
    assign bus.dump_last       = (state_q == DUMP) && (cnt_q == LAST_CNT);
    assign bus.phase           = state_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against an array model
// of the RAM and a queue of expected dump words.
module tb_data_mem_responder;
    localparam int          DEPTH = 256;
    localparam int          AW    = 8;
    localparam logic [31:0] DONE  = 32'h0000_0FFC;
    localparam int          BASE  = 0;
    localparam int          LEN   = 4;

    logic clk;
    logic reset;

    data_mem_responder_if #(.AW(AW)) bus ();

    data_mem_responder #(
        .DEPTH_WORDS(DEPTH),
        .DONE_ADDR  (DONE),
        .DUMP_BASE  (BASE),
        .DUMP_LEN   (LEN)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int          checks;
    int          errors;
    logic [31:0] refMem [DEPTH];
    logic [31:0] dumpQ [$];
    logic [31:0] rnd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time exceeded, observed no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic mw, input logic [31:0] addr, input logic [31:0] wd,
                                 input logic lv, input logic [AW-1:0] la, input logic [31:0] ld,
                                 input logic ll, input logic dr);
        bus.MemWrite        = mw;
        bus.ALUResult       = addr;
        bus.WriteData       = wd;
        bus.host_load_valid = lv;
        bus.host_load_addr  = la;
        bus.host_load_data  = ld;
        bus.host_load_last  = ll;
        bus.dump_ready      = dr;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, '0, 32'h0, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] refRead(input logic [31:0] addr);
        if (addr < 32'(DEPTH * 4)) return refMem[int'(addr >> 2)];
        return 32'h0;
    endfunction

    task automatic readCheck(input string tag, input logic [31:0] addr);
        bus.MemWrite  = 1'b0;
        bus.ALUResult = addr;
        #1;
        checkOutput(tag, bus.ReadData, refRead(addr));
    endtask

    // Reset cycle carries a host load and a CPU store to word 7; both must be lost.
    task automatic resetPulse();
        reset = 1'b1;
        applyStimulus(1'b1, 32'h1C, $urandom, 1'b1, AW'(7), $urandom, 1'b1, 1'b1);
        cycle();
        reset = 1'b0;
        idleInputs();
        checkOutput("rst phase", bus.phase, 0);
        checkOutput("rst start", bus.start, 0);
        checkOutput("rst dump_valid", bus.dump_valid, 0);
        checkOutput("rst dump_last", bus.dump_last, 0);
        checkOutput("rst load_ready", bus.host_load_ready, 1);
        checkOutput("rst dump_data", bus.dump_data, refMem[BASE]);
    endtask

    task automatic loadLast();
        int idx;
        idx = $urandom_range(8, 15);
        rnd = $urandom;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, AW'(idx), rnd, 1'b1, 1'b0);
        cycle();
        refMem[idx] = rnd;
        idleInputs();
        checkOutput("last load phase", bus.phase, 1);
        checkOutput("last load start", bus.start, 1);
    endtask

    task automatic sweepRetained();
        for (int i = 0; i < 16; i++) begin
            idleInputs();
            readCheck("retained word", 32'(i * 4));
            cycle();
        end
    endtask

    task automatic runRandom(input int n);
        logic [31:0] addr;
        logic [31:0] wd;
        int k;
        for (int i = 0; i < n; i++) begin
            k = $urandom_range(0, 9);
            if (k < 5)      addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            else if (k < 8) addr = 32'($urandom_range(0, DEPTH * 4 - 1));
            else begin
                addr = $urandom | 32'h0000_0400;
                if (addr == DONE) addr = 32'h8000_0000;
            end
            wd = $urandom;
            applyStimulus(1'b1, addr, wd, 1'($urandom_range(0, 1)), AW'($urandom), $urandom,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            cycle();
            if (addr < 32'(DEPTH * 4)) refMem[int'(addr >> 2)] = wd;
            checkOutput("run phase", bus.phase, 1);
            checkOutput("run start", bus.start, 1);
            checkOutput("run dump_valid", bus.dump_valid, 0);
            readCheck("run readback", addr);
        end
    endtask

    // mode 0: ready held high, 1: ready pattern 1,0,0,1, 2: random ready.
    task automatic doneAndDump(input int mode, input int abortAfter);
        int   taken;
        int   cyc;
        logic r;
        rnd = $urandom;
        applyStimulus(1'b1, 32'h4, rnd, 1'b0, '0, 32'h0, 1'b0, 1'b0);
        cycle();
        refMem[1] = rnd;
        applyStimulus(1'b1, DONE, $urandom, 1'b0, '0, 32'h0, 1'b0, 1'b0);
        cycle();
        dumpQ = {};
        for (int i = 0; i < LEN; i++) dumpQ.push_back(refMem[BASE + i]);
        checkOutput("done start falls", bus.start, 0);
        checkOutput("done dump_valid", bus.dump_valid, 1);
        checkOutput("done phase", bus.phase, 2);
        taken = 0;
        cyc   = 0;
        while (taken < LEN && cyc < 100) begin
            if (abortAfter >= 0 && taken == abortAfter) break;
            if (mode == 0)      r = 1'b1;
            else if (mode == 1) r = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            else                r = 1'($urandom_range(0, 1));
            applyStimulus(1'($urandom_range(0, 1)), $urandom & 32'h3FC, $urandom, 1'($urandom_range(0, 1)),
                          AW'($urandom), $urandom, 1'($urandom_range(0, 1)), r);
            checkOutput("dump valid", bus.dump_valid, 1);
            checkOutput("dump data", bus.dump_data, dumpQ[taken]);
            checkOutput("dump last", bus.dump_last, (taken == LEN - 1) ? 1 : 0);
            checkOutput("dump start low", bus.start, 0);
            cycle();
            cyc++;
            if (r) taken++;
        end
        if (abortAfter < 0) begin
            idleInputs();
            checkOutput("dump words taken", taken, LEN);
            if (mode == 0) checkOutput("dump cycles", cyc, LEN);
            checkOutput("end phase", bus.phase, 3);
            checkOutput("end dump_valid", bus.dump_valid, 0);
            checkOutput("end dump_last", bus.dump_last, 0);
            checkOutput("end start", bus.start, 0);
            checkOutput("end load_ready", bus.host_load_ready, 0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        idleInputs();
        cycle();
        cycle();
        checkOutput("init phase", bus.phase, 0);
        checkOutput("init start", bus.start, 0);
        checkOutput("init load_ready", bus.host_load_ready, 1);
        checkOutput("init dump_valid", bus.dump_valid, 0);
        checkOutput("init dump_last", bus.dump_last, 0);
        reset = 1'b0;

        // Preload every word so the model knows the whole RAM; CPU stores must be ignored.
        for (int i = 0; i < DEPTH; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                applyStimulus(1'b1, $urandom & 32'h3FC, $urandom, 1'b0, '0, 32'h0, 1'b0, 1'b0);
                cycle();
            end
            rnd = $urandom;
            applyStimulus(1'($urandom_range(0, 1)), $urandom & 32'h3FC, $urandom, 1'b1, AW'(i), rnd,
                          1'b0, 1'($urandom_range(0, 1)));
            cycle();
            refMem[i] = rnd;
        end
        idleInputs();
        checkOutput("preload phase", bus.phase, 0);
        checkOutput("preload start", bus.start, 0);
        checkOutput("preload load_ready", bus.host_load_ready, 1);

        applyStimulus(1'b1, 32'h0, 32'h55, 1'b0, '0, 32'h0, 1'b0, 1'b0);
        cycle();
        readCheck("load ignores cpu", 32'h0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, AW'(i), 32'(i + 1), (i == 3), 1'b0);
            cycle();
            refMem[i] = 32'(i + 1);
            checkOutput("start timing", bus.start, (i == 3) ? 1 : 0);
            checkOutput("phase after load", bus.phase, (i == 3) ? 1 : 0);
        end
        idleInputs();
        readCheck("read addr 8", 32'h8);
        checkOutput("read addr 8 const", bus.ReadData, 32'd3);
        checkOutput("run load_ready", bus.host_load_ready, 0);

        applyStimulus(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, '0, 32'h0, 1'b0, 1'b0);
        cycle();
        refMem[4] = 32'hDEAD_BEEF;
        readCheck("store 0x10", 32'h10);
        readCheck("store 0x13", 32'h13);
        applyStimulus(1'b1, 32'h0001_0000, 32'h1234_5678, 1'b0, '0, 32'h0, 1'b0, 1'b0);
        cycle();
        readCheck("oor read", 32'h0001_0000);
        readCheck("oor no alias", 32'h0);

        runRandom(40);
        doneAndDump(1, -1);

        applyStimulus(1'b1, 32'h8, 32'hCAFE_F00D, 1'b1, AW'(2), 32'h0BAD_0BAD, 1'b1, 1'b1);
        cycle();
        idleInputs();
        readCheck("done ignores writes", 32'h8);
        checkOutput("done holds", bus.phase, 3);

        resetPulse();
        loadLast();
        sweepRetained();
        runRandom(20);
        doneAndDump(0, -1);

        resetPulse();
        loadLast();
        runRandom(10);
        doneAndDump(2, 2);
        resetPulse();
        loadLast();
        sweepRetained();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the pipelined CPU's data port: it answers the core's `MemWrite`/`ALUResult`/`WriteData`/`ReadData` accesses from a word-addressed RAM. It also sequences a run. First, a host preloads RAM (for example the RSA operands and key) over a valid/ready port. Then it raises `start` to release the core. When the core stores to a sentinel "done" address, it streams a result window back to the host over a second valid/ready port.

## Interface
- `DEPTH_WORDS`, 256: RAM size in 32-bit words; a power of two. `AW = log2(DEPTH_WORDS)`.
- `DONE_ADDR`, 32'h0000_0FFC: byte address that the core stores to in order to signal completion.
- `DUMP_BASE`, 0: first word index returned to the host.
- `DUMP_LEN`, 16: number of words returned to the host; at least 1, and `DUMP_BASE+DUMP_LEN <= DEPTH_WORDS`.
- `clk`, input, 1: the single clock; every register updates on its rising edge.
- `reset`, input, 1: synchronous, active-high.
- `MemWrite`, input, 1: store strobe from the CPU.
- `ALUResult`, input, 32: CPU byte address.
- `WriteData`, input, 32: CPU store data.
- `ReadData`, output, 32: load data returned to the CPU (combinational).
- `start`, output, 1: run enable to the CPU (registered).
- `host_load_valid`, input, 1: host load word is present.
- `host_load_ready`, output, 1: the block accepts load words.
- `host_load_addr`, input, AW: word index for the load.
- `host_load_data`, input, 32: load data.
- `host_load_last`, input, 1: marks the final load word.
- `dump_valid`, output, 1: a result word is presented to the host.
- `dump_ready`, input, 1: the host accepts the result word.
- `dump_data`, output, 32: result word.
- `dump_last`, output, 1: marks the final result word.
- `phase`, output, 2: current state (LOAD=0, RUN=1, DUMP=2, DONE=3).

## Operation
- States are LOAD → RUN → DUMP → DONE; DONE holds until `reset`.
- Word index is `ALUResult[AW+1:2]`. Bits [1:0] are ignored. An address is in range iff `ALUResult[31:AW+2]==0`.
- LOAD:
  - `host_load_ready=1`.
  - On `host_load_valid && host_load_ready`: `mem[host_load_addr] <= host_load_data`.
  - If `host_load_last` is also set, go to RUN.
  - CPU `MemWrite` is ignored in this state.
- RUN:
  - `start=1` and `host_load_ready=0`.
  - If `MemWrite` with `ALUResult==DONE_ADDR`: do not write the array, go to DUMP.
  - Else if `MemWrite` with an in-range address: write `WriteData` to the word.
  - Out-of-range stores are dropped.
- `ReadData`:
  - Driven in every state.
  - Equals the addressed word for an in-range `ALUResult`, otherwise 0.
- DUMP:
  - `dump_valid=1` and `dump_data=mem[DUMP_BASE+cnt]`, where `cnt` runs 0..`DUMP_LEN-1`.
  - `dump_last=(cnt==DUMP_LEN-1)`.
  - On a `dump_valid && dump_ready` handshake: `cnt` increments. If `dump_last` was set, go to DONE.
  - Inputs on the load port and the CPU port are ignored.
- DONE: all strobes are low and `ReadData` still reflects the RAM.
- RAM contents are not cleared by `reset`. Only state, `cnt` and `start` are reset.

## Timing
- Reset values:
  - `phase=LOAD`, `start=0`, `host_load_ready=1`, `dump_valid=0`, `dump_last=0`, `dump_data=mem[DUMP_BASE]`.
  - `cnt=0`; `ReadData` is combinational from the RAM.
- Writes commit at the clock edge. A word written in cycle n is visible on `ReadData`/`dump_data` from cycle n+1.
- Last load handshake in cycle n → `phase=RUN` and `start=1` in cycle n+1.
- DONE store in cycle n → `start=0` and `dump_valid=1` in cycle n+1. The first dump word includes every CPU store from cycle n-1 or earlier.
- The dump stream is one word per cycle when `dump_ready` is held high. `DUMP_LEN` words take exactly `DUMP_LEN` cycles.
- While `dump_valid && !dump_ready`, `dump_data` and `dump_last` stay stable.
- Reset asserted in any state:
  - Next cycle is LOAD with `start=0`.
  - A pending dump is abandoned.
  - A load or CPU write in the reset cycle is discarded.
- A load handshake with `host_load_last=0` stays in LOAD indefinitely. There is no timeout.

## Test plan
- Reset, then load words 0..3 = 1,2,3,4 with `last` on the fourth word. Required: `start` rises exactly one cycle after that handshake, and `ReadData` at `ALUResult=8` is 3.
- In RUN, store 0xDEADBEEF to 0x10. Required: `ReadData` at 0x10 (and at 0x13) returns 0xDEADBEEF the next cycle. A store to 0x0001_0000 is dropped and reads return 0.
- In LOAD, assert `MemWrite` at 0x0 with 0x55. Required: `mem[0]` is unchanged.
- Store to `DONE_ADDR` with `DUMP_LEN=4` and `dump_ready` held high. Required: `start` falls and `dump_valid` rises the next cycle; four words `mem[0..3]` stream out; `dump_last` is set only on the fourth; then `phase=DONE`.
- During DUMP, toggle `dump_ready` 1,0,0,1. Required: data is held across the stalled cycles, no word is skipped or duplicated, and `cnt` advances only on handshakes.
- Assert `reset` mid-dump after 2 words. Required: next cycle `phase=LOAD` and `dump_valid=0`; RAM contents are retained, verified by reading them back in RUN after a new load with `last`.
